uart_rx_gen: RTL
================

Name: uart_rx_gen

Overview:
- Parametrised UART receiver; next-generation serial front end for the LED-matrix command path.
- Generalises the fixed 8N1 receiver:
  - configurable data width, parity and stop bits;
  - runtime baud divider;
  - 3-sample majority vote per bit;
  - framing, parity, overrun and break detection;
  - small output FIFO with valid/ready handshake.
- Sits between the board rx pin and the frame/command decoder.

Parameters:
- DATA_BITS, 8, data bits per frame; legal 5..9; sent LSB first.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, 1 or 2.
- OVERSAMPLE, 16, baud ticks per bit; legal 8..32.
- DIV_WIDTH, 16, width of the runtime divider input.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, at least 2.

Ports:
- clk, input, 1, single clock.
- reset, input, 1, synchronous, active-low reset (0 = reset).
- rx, input, 1, asynchronous serial line; idles high.
- divider, input, DIV_WIDTH, an oversample tick fires every divider+1 clk cycles.
- data, output, DATA_BITS, received word at the FIFO head.
- valid, output, 1, FIFO head holds an entry.
- ready, input, 1, consumer accepts the head entry when valid && ready.
- parity_error, output, 1, parity error flag of the head entry.
- framing_error, output, 1, framing error flag of the head entry.
- overrun, output, 1, one-cycle pulse when a frame is dropped because the FIFO is full.
- break_detect, output, 1, one-cycle pulse on a detected break.

Behaviour:
- Reset (reset == 0 at a clk edge):
  - state = IDLE; FIFO emptied.
  - valid, data, parity_error, framing_error, overrun, break_detect all 0.
  - Synchroniser flops = 1; tick counter = 0.
  - A reset mid-frame abandons the frame; nothing is pushed.
- Synchroniser: 2-flop chain on rx; rx_s is the second stage. All decisions use rx_s.
- Tick generator:
  - Counter runs 0..divider; tick pulses for one clk when counter == divider, then the counter wraps to 0.
  - divider = 0 gives a tick every clk.
  - A divider change takes effect at the next wrap.
- Bit phase counter: 0..OVERSAMPLE-1, advanced on ticks only while state != IDLE.
- Majority vote:
  - M = OVERSAMPLE/2.
  - rx_s is sampled on the ticks at phases M-1, M and M+1.
  - The vote is resolved at phase M+1 as the 2-of-3 majority.
- States and transitions:
  - IDLE: on a tick with rx_s == 0, go to START with phase = 0.
  - START: if the vote is 1, return to IDLE (glitch; no flags, no push). Otherwise go to DATA at the end of the bit (phase OVERSAMPLE-1).
  - DATA: the vote is shifted in LSB-first. After DATA_BITS bits, go to PARITY if PARITY != 0, else to STOP.
  - PARITY: the voted bit is compared with the XOR of the data bits.
    - Odd: the XOR of data and parity bit must be 1.
    - Even: it must be 0.
    - A mismatch sets the frame's parity_error.
  - STOP: any stop-bit vote of 0 sets the frame's framing_error. At the vote of the last stop bit (not the end of the bit), the frame is committed and the state returns to IDLE, so the next start edge can be caught half a bit early.
  - BREAK_WAIT: stay until a tick sees rx_s == 1, then go to IDLE.
- Break:
  - Condition: framing error and all data, parity and stop votes are 0.
  - Response: no FIFO push; break_detect pulses for 1 clk; go to BREAK_WAIT instead of IDLE.
  - Exactly one pulse per continuous low period.
- Commit:
  - Pushes {data, parity_error, framing_error}; frames with errors are still pushed.
  - If the FIFO is full and no pop happens in the same cycle, the frame is dropped and overrun pulses for 1 clk.
  - A push and pop in the same cycle while full is accepted with no overrun.
- Output:
  - valid = FIFO non-empty.
  - data and flags present the head entry and stay stable while valid && !ready.
  - A pop occurs on a clk edge with valid && ready.
  - Latency: valid rises 1 clk after the commit cycle when the FIFO was empty.
- FIFO pointers: log2(FIFO_DEPTH)+1 bits wide, wrapping modulo 2*FIFO_DEPTH.
  - Full = MSBs differ and the low bits are equal.
  - Empty = pointers equal.

Test Plan:
1. Clean frame: DATA_BITS=8, PARITY=0, STOP_BITS=1, OVERSAMPLE=16, divider=0, ready=1; send 0xA5 at 16 clk/bit → one valid pulse with data=0xA5, parity_error=0, framing_error=0; valid rises 2 clk after the last stop-bit vote.
2. Glitch rejection: rx low for 4 ticks, then high → no valid; the module returns to IDLE. A following 0x3C frame is received correctly.
3. Parity: PARITY=2 (even); send 0x03 with parity bit 1 → data=0x03, parity_error=1. Send 0x03 with parity bit 0 → parity_error=0.
4. Framing and break:
   - 0x55 with stop bit 0 → data=0x55, framing_error=1.
   - rx held low for 30 bit times → exactly one break_detect pulse and no FIFO entry.
   - After rx returns high, 0x81 is received clean.
5. Overrun: FIFO_DEPTH=4, ready=0; send 0x01..0x05 → overrun pulses once, on the 5th commit. With ready=1, pops yield 0x01..0x04 in order, then valid=0.
6. Reset mid-frame: assert reset during bit 4 of 0xF0 → all outputs 0 and the FIFO empty. After deassertion, 0x5A is received correctly; divider=3 (4 clk/tick) also decodes 0x5A at 64 clk/bit.

Source files
------------

// File: rtl/uart_rx_gen.sv
// rtl/uart_rx_gen.sv - parametrised oversampling UART receiver with majority vote, error/break detection and output FIFO
module uart_rx_gen #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic [DIV_WIDTH-1:0] divider,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 break_detect
);

  localparam int PW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_BITS + 2;
  localparam int M  = OVERSAMPLE / 2;
  localparam logic [PW-1:0] PH_SA   = PW'(M - 1);
  localparam logic [PW-1:0] PH_SB   = PW'(M);
  localparam logic [PW-1:0] PH_VOTE = PW'(M + 1);
  localparam logic [PW-1:0] PH_END  = PW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK_WAIT
  } state_t;

  state_t                 state;
  logic                   rx_m, rx_s;
  logic [DIV_WIDTH-1:0]   tick_cnt, div_q;
  logic                   tick;
  logic [PW-1:0]          phase;
  logic [BW-1:0]          bit_cnt;
  logic                   stop_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic                   s_a, s_b, vote_now;
  logic                   pe_acc, fe_acc, seen_one;
  logic                   fe_final, is_break;
  logic                   push;
  logic [EW-1:0]          push_word;
  logic [EW-1:0]          mem [FIFO_DEPTH];
  logic [AW:0]            wr_ptr, rd_ptr;
  logic                   empty, full, pop, do_push;
  logic [EW-1:0]          head;

  assign tick     = (tick_cnt == div_q);
  assign vote_now = (s_a & s_b) | (s_a & rx_s) | (s_b & rx_s);
  assign fe_final = fe_acc | ~vote_now;
  assign is_break = fe_final & ~(seen_one | vote_now);

  // Two-flop synchroniser; the line idles high so the chain resets to 1
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Oversample tick; the divider is re-latched only at a wrap so a change never shortens a period
  always_ff @(posedge clk) begin
    if (!reset) begin
      tick_cnt <= '0;
      div_q    <= divider;
    end else if (tick) begin
      tick_cnt <= '0;
      div_q    <= divider;
    end else begin
      tick_cnt <= tick_cnt + DIV_WIDTH'(1);
    end
  end

  // Frame FSM: phase tracking, 3-sample vote, shift-in, error accumulation and commit
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      phase        <= '0;
      bit_cnt      <= '0;
      stop_cnt     <= 1'b0;
      shreg        <= '0;
      s_a          <= 1'b1;
      s_b          <= 1'b1;
      pe_acc       <= 1'b0;
      fe_acc       <= 1'b0;
      seen_one     <= 1'b0;
      push         <= 1'b0;
      push_word    <= '0;
      break_detect <= 1'b0;
    end else begin
      push         <= 1'b0;
      break_detect <= 1'b0;
      if (tick) begin
        if (state != S_IDLE) begin
          phase <= (phase == PH_END) ? '0 : phase + PW'(1);
          if (phase == PH_SA) s_a <= rx_s;
          if (phase == PH_SB) s_b <= rx_s;
        end
        case (state)
          S_IDLE: begin
            if (!rx_s) begin
              state <= S_START;
              phase <= '0;
            end
          end
          S_START: begin
            if (phase == PH_VOTE && vote_now) begin
              state <= S_IDLE;
            end else if (phase == PH_END) begin
              state    <= S_DATA;
              bit_cnt  <= '0;
              pe_acc   <= 1'b0;
              fe_acc   <= 1'b0;
              seen_one <= 1'b0;
            end
          end
          S_DATA: begin
            if (phase == PH_VOTE) begin
              shreg <= {vote_now, shreg[DATA_BITS-1:1]};
              if (vote_now) seen_one <= 1'b1;
            end
            if (phase == PH_END) begin
              bit_cnt <= bit_cnt + BW'(1);
              if (bit_cnt == BW'(DATA_BITS - 1)) begin
                state    <= (PARITY != 0) ? S_PARITY : S_STOP;
                stop_cnt <= 1'b0;
              end
            end
          end
          S_PARITY: begin
            if (phase == PH_VOTE) begin
              pe_acc <= (PARITY == 1) ? ~(^shreg ^ vote_now) : (^shreg ^ vote_now);
              if (vote_now) seen_one <= 1'b1;
            end
            if (phase == PH_END) begin
              state    <= S_STOP;
              stop_cnt <= 1'b0;
            end
          end
          S_STOP: begin
            // The last stop bit commits at its vote so a new start edge can be caught early
            if (phase == PH_VOTE) begin
              if (stop_cnt == 1'(STOP_BITS - 1)) begin
                if (is_break) begin
                  break_detect <= 1'b1;
                  state        <= S_BREAK_WAIT;
                end else begin
                  push      <= 1'b1;
                  push_word <= {shreg, pe_acc, fe_final};
                  state     <= S_IDLE;
                end
              end else begin
                fe_acc <= fe_final;
                if (vote_now) seen_one <= 1'b1;
              end
            end
            if (phase == PH_END) stop_cnt <= 1'b1;
          end
          S_BREAK_WAIT: begin
            if (rx_s) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign valid   = !empty;
  assign pop     = valid && ready;
  assign do_push = push && (!full || pop);

  // FIFO pointers and overrun pulse; a push into a full FIFO survives only if the head pops in the same cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= push && full && !pop;
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // FIFO storage; contents are masked at the outputs while empty so no reset is needed here
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_word;
  end

  assign head          = mem[rd_ptr[AW-1:0]];
  assign data          = valid ? head[EW-1:2] : '0;
  assign parity_error  = valid & head[1];
  assign framing_error = valid & head[0];

endmodule
